cpu_ad48: RTL and testbench

//  Single-issue 48-bit CPU core with split register banks: 8 address regs A0-A7 and 8 data regs D0-D7.

---
 rtl/cpu_ad48_pkg.sv | 108 ++++++++++
 rtl/cpu_ad48_if.sv | 23 ++
 rtl/cpu_ad48_mem.sv | 29 ++
 rtl/cpu_ad48.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_ad48.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ad48_pkg.sv
// ============================================================================
// Module   : cpu_ad48_pkg
// Brief    : Shared types, encodings, ALU helper and instruction encoders
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_ad48_pkg;

    localparam int XLEN = 48;

    typedef enum logic [3:0] {
        OP_SYS    = 4'd0,
        OP_ALU    = 4'd1,
        OP_ALUI_A = 4'd2,
        OP_ALUI_D = 4'd3,
        OP_LD     = 4'd4,
        OP_ST     = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        F_ADD = 4'd0,
        F_SUB = 4'd1,
        F_AND = 4'd2,
        F_OR  = 4'd3,
        F_XOR = 4'd4,
        F_SHL = 4'd5,
        F_SHR = 4'd6,
        F_SAR = 4'd7
    } funct_e;

    localparam logic [3:0] c_SYS_NOP  = 4'h0;
    localparam logic [3:0] c_SYS_BRK  = 4'h1;
    localparam logic [3:0] c_SYS_HALT = 4'hF;

    localparam logic [3:0] c_CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] c_CAUSE_BRK      = 4'd3;
    localparam logic [3:0] c_CAUSE_LD_FAULT = 4'd4;
    localparam logic [3:0] c_CAUSE_ST_FAULT = 4'd6;

    // Shift amounts use only the low 6 bits of the second operand.
    function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [5:0] sh;
        sh = b[5:0];
        case (op)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            F_SHL:   return a << sh;
            F_SHR:   return a >> sh;
            F_SAR:   return XLEN'($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] to48(input longint v);
        return v[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] pack_subop(input logic [3:0] s);
        return {17'b0, s, 27'b0};
    endfunction

    function automatic logic [XLEN-1:0] pack_imm27(input logic [26:0] imm);
        return {21'b0, imm};
    endfunction

    function automatic logic [XLEN-1:0] pack_disp33(input logic [32:0] disp);
        return {15'b0, disp};
    endfunction

    function automatic logic [XLEN-1:0] instr_alu(input logic bank, input logic [2:0] rd,
                                                  input logic [2:0] rs1, input logic [2:0] rs2,
                                                  input logic [3:0] funct);
        return {OP_ALU, bank, rd, rs1, rs2, funct, 30'b0};
    endfunction

    function automatic logic [XLEN-1:0] instr_alui_a(input logic [2:0] rd, input logic [2:0] rs1,
                                                     input logic [3:0] subop, input logic [26:0] imm);
        return {OP_ALUI_A, 1'b0, rd, rs1, 37'b0} | pack_subop(subop) | pack_imm27(imm);
    endfunction

    function automatic logic [XLEN-1:0] instr_alui_d(input logic [2:0] rd, input logic [2:0] rs1,
                                                     input logic [3:0] subop, input logic [26:0] imm);
        return {OP_ALUI_D, 1'b1, rd, rs1, 37'b0} | pack_subop(subop) | pack_imm27(imm);
    endfunction

    function automatic logic [XLEN-1:0] instr_ld(input logic bank, input logic [2:0] rd,
                                                 input logic [2:0] rs1, input logic [32:0] disp);
        return {OP_LD, bank, rd, rs1, 37'b0} | pack_disp33(disp);
    endfunction

    function automatic logic [XLEN-1:0] instr_st(input logic bank, input logic [2:0] rd,
                                                 input logic [2:0] rs1, input logic [32:0] disp);
        return {OP_ST, bank, rd, rs1, 37'b0} | pack_disp33(disp);
    endfunction

    function automatic logic [XLEN-1:0] instr_sys(input logic [3:0] func);
        return {OP_SYS, 40'b0, func};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ad48_if.sv
// ============================================================================
// Module   : cpu_ad48_if
// Brief    : Word-addressed memory port: combinational read, clocked write
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_ad48_if
    import cpu_ad48_pkg::*;
#(
    parameter int AW = 10
);
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    modport master (output raddr, we, waddr, wdata, input rdata);
    modport slave  (input raddr, we, waddr, wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/cpu_ad48_mem.sv
// ============================================================================
// Module   : cpu_ad48_mem
// Brief    : 48-bit word memory, async read / posedge write, never reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_ad48_mem
    import cpu_ad48_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input  logic           clk,
    cpu_ad48_if.slave      bus
);

    logic [XLEN-1:0] mem [WORDS];

    assign bus.rdata = mem[bus.raddr];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ad48.sv
// ============================================================================
// Module   : cpu_ad48
// Brief    : Single-issue 48-bit A/D-bank core with precise traps and HALT
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_ad48
    import cpu_ad48_pkg::*;
#(
    parameter int              IM_WORDS    = 1024,
    parameter int              DM_WORDS    = 1024,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 48'd64
) (
    input  logic clk,
    input  logic rst
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);

    logic [XLEN-1:0] pc;
    logic            halt;
    logic [XLEN-1:0] csr_epc;
    logic [XLEN-1:0] csr_cause;
    logic [XLEN-1:0] csr_status;
    logic [XLEN-1:0] csr_instret;
    logic [1:0]      priv_mode;
    logic [XLEN-1:0] r_a_regs [8];
    logic [XLEN-1:0] r_d_regs [8];

    cpu_ad48_if #(.AW(IM_AW)) imem_bus ();
    cpu_ad48_if #(.AW(DM_AW)) dmem_bus ();

    cpu_ad48_mem #(.WORDS(IM_WORDS)) IMEM (.clk(clk), .bus(imem_bus.slave));
    cpu_ad48_mem #(.WORDS(DM_WORDS)) DMEM (.clk(clk), .bus(dmem_bus.slave));

    // Index 0 of either bank is hardwired to zero on read.
    function automatic logic [XLEN-1:0] rf_read(input logic bank, input logic [2:0] idx);
        if (idx == 3'd0) begin
            return '0;
        end
        return bank ? r_d_regs[idx] : r_a_regs[idx];
    endfunction

    logic [XLEN-1:0] w_instr;
    logic [3:0]      w_opcode;
    logic            w_bank;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs1;
    logic [2:0]      w_rs2;
    logic [3:0]      w_funct;
    logic [3:0]      w_subop;
    logic [3:0]      w_sysfn;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_disp;

    assign w_instr  = imem_bus.rdata;
    assign w_opcode = w_instr[47:44];
    assign w_bank   = w_instr[43];
    assign w_rd     = w_instr[42:40];
    assign w_rs1    = w_instr[39:37];
    assign w_rs2    = w_instr[36:34];
    assign w_funct  = w_instr[33:30];
    assign w_subop  = w_instr[30:27];
    assign w_sysfn  = w_instr[3:0];
    assign w_imm    = {{21{w_instr[26]}}, w_instr[26:0]};
    assign w_disp   = {{15{w_instr[32]}}, w_instr[32:0]};

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [3:0]      w_alu_sel;
    logic            w_wr_en;
    logic            w_wr_bank;
    logic            w_illegal;
    logic            w_brk;
    logic            w_halt_op;
    logic            w_ld;
    logic            w_st;

    always_comb begin
        w_op_a    = '0;
        w_op_b    = '0;
        w_alu_sel = F_ADD;
        w_wr_en   = 1'b0;
        w_wr_bank = 1'b0;
        w_illegal = 1'b0;
        w_brk     = 1'b0;
        w_halt_op = 1'b0;
        w_ld      = 1'b0;
        w_st      = 1'b0;
        case (w_opcode)
            OP_SYS: begin
                case (w_sysfn)
                    c_SYS_NOP:  ;
                    c_SYS_BRK:  w_brk = 1'b1;
                    c_SYS_HALT: w_halt_op = 1'b1;
                    default:    w_illegal = 1'b1;
                endcase
            end
            OP_ALU: begin
                w_op_a    = rf_read(w_bank, w_rs1);
                w_op_b    = rf_read(w_bank, w_rs2);
                w_alu_sel = w_funct;
                w_illegal = w_funct[3];
                w_wr_en   = 1'b1;
                w_wr_bank = w_bank;
            end
            OP_ALUI_A, OP_ALUI_D: begin
                w_wr_bank = (w_opcode == OP_ALUI_D);
                w_op_a    = rf_read(w_wr_bank, w_rs1);
                w_op_b    = w_imm;
                w_alu_sel = w_subop;
                w_illegal = w_subop[3];
                w_wr_en   = 1'b1;
            end
            OP_LD: begin
                w_ld      = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_bank = w_bank;
            end
            OP_ST: begin
                w_st = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] w_ea;
    logic            w_ea_fault;
    logic            w_exc;
    logic [3:0]      w_cause;
    logic [XLEN-1:0] w_wb_data;

    assign w_ea       = rf_read(1'b0, w_rs1) + w_disp;
    assign w_ea_fault = (w_ea >= XLEN'(DM_WORDS));
    assign w_exc      = w_illegal | w_brk | ((w_ld | w_st) & w_ea_fault);

    // Priority: illegal, then BRK, then load fault, then store fault.
    always_comb begin
        w_cause = c_CAUSE_ST_FAULT;
        if (w_illegal) begin
            w_cause = c_CAUSE_ILLEGAL;
        end else if (w_brk) begin
            w_cause = c_CAUSE_BRK;
        end else if (w_ld) begin
            w_cause = c_CAUSE_LD_FAULT;
        end
    end

    assign w_wb_data = w_ld ? dmem_bus.rdata : alu_op(w_alu_sel, w_op_a, w_op_b);

    assign imem_bus.raddr = pc[IM_AW-1:0];
    assign imem_bus.we    = 1'b0;
    assign imem_bus.waddr = '0;
    assign imem_bus.wdata = '0;

    assign dmem_bus.raddr = w_ea[DM_AW-1:0];
    assign dmem_bus.waddr = w_ea[DM_AW-1:0];
    assign dmem_bus.wdata = rf_read(w_bank, w_rd);
    assign dmem_bus.we    = w_st & ~w_exc & ~halt & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            halt        <= 1'b0;
            csr_epc     <= '0;
            csr_cause   <= '0;
            csr_status  <= XLEN'(3);
            csr_instret <= '0;
            priv_mode   <= 2'd3;
            for (int i = 0; i < 8; i++) begin
                r_a_regs[i] <= '0;
                r_d_regs[i] <= '0;
            end
        end else if (!halt) begin
            if (w_exc) begin
                csr_epc         <= pc;
                csr_cause       <= {44'b0, w_cause};
                priv_mode       <= 2'd3;
                csr_status[1:0] <= 2'd3;
                pc              <= TRAP_VECTOR;
            end else if (w_halt_op) begin
                halt <= 1'b1;
            end else begin
                pc          <= pc + 1'b1;
                csr_instret <= csr_instret + 1'b1;
                if (w_wr_en && (w_rd != 3'd0)) begin
                    if (w_wr_bank) begin
                        r_d_regs[w_rd] <= w_wb_data;
                    end else begin
                        r_a_regs[w_rd] <= w_wb_data;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ad48.sv
// ============================================================================
// Module   : tb_cpu_ad48
// Brief    : Directed vector bench for cpu_ad48 (traps, ALU, load/store, reset)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ad48;
    import cpu_ad48_pkg::*;

    localparam int              DMW = 1024;
    localparam int              IMW = 1024;
    localparam logic [47:0]     TV  = 48'd32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_ad48 #(.IM_WORDS(IMW), .DM_WORDS(DMW), .TRAP_VECTOR(TV)) dut (
        .clk (clk),
        .rst (rst)
    );

    int total = 0;
    int bad   = 0;
    logic [47:0] prog [4];
    int          nprog;

    typedef struct {
        string       name;
        logic [47:0] p0, p1, p2, p3;
        int          n;
        logic [47:0] pc, epc, cause, instret;
    } exc_vec_t;

    typedef struct {
        string       name;
        logic [3:0]  f;
        logic [26:0] ia, ib;
        logic [47:0] exp;
    } alu_vec_t;

    exc_vec_t ev [10];
    alu_vec_t av [9];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Fills IMEM with HALT, loads prog[], applies reset and checks reset state.
    task automatic load_and_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < IMW; i++) dut.IMEM.mem[i] = instr_sys(c_SYS_HALT);
        for (int i = 0; i < nprog; i++) dut.IMEM.mem[i] = prog[i];
        @(negedge clk);
        check({name, ".rst_pc"}, dut.pc, 48'd0);
        check({name, ".rst_instret"}, dut.csr_instret, 48'd0);
        check({name, ".rst_halt"}, 48'(dut.halt), 48'd0);
        check({name, ".rst_epc"}, dut.csr_epc, 48'd0);
        check({name, ".rst_cause"}, dut.csr_cause, 48'd0);
        check({name, ".rst_priv"}, 48'(dut.priv_mode), 48'd3);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int max_cycles);
        int n;
        n = 0;
        while (dut.halt !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (dut.halt !== 1'b1) check({name, ".halt_timeout"}, 48'(dut.halt), 48'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev[0] = '{"illegal_funct", instr_alu(1'b0, 3'd1, 3'd0, 3'd0, 4'hF), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd2, 48'd0};
        ev[1] = '{"brk", instr_sys(c_SYS_BRK), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd3, 48'd0};
        ev[2] = '{"ld_fault", instr_alui_a(3'd1, 3'd0, F_ADD, 27'd0),
                  instr_ld(1'b1, 3'd2, 3'd1, 33'd1024), 48'd0, 48'd0, 2,
                  48'd32, 48'd1, 48'd4, 48'd1};
        ev[3] = '{"st_fault", instr_alui_a(3'd1, 3'd0, F_ADD, 27'd0),
                  instr_alui_d(3'd1, 3'd0, F_ADD, 27'd5),
                  instr_st(1'b1, 3'd1, 3'd1, 33'd1024), 48'd0, 3,
                  48'd32, 48'd2, 48'd6, 48'd2};
        ev[4] = '{"illegal_opcode", to48(64'h6000_0000_0000), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd2, 48'd0};
        ev[5] = '{"illegal_subop", instr_alui_d(3'd1, 3'd0, 4'h8, 27'd1), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd2, 48'd0};
        ev[6] = '{"illegal_sysfn", instr_sys(4'h2), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd2, 48'd0};
        ev[7] = '{"nop_nop_brk", instr_sys(c_SYS_NOP), instr_sys(c_SYS_NOP), instr_sys(c_SYS_BRK),
                  48'd0, 3, 48'd32, 48'd2, 48'd3, 48'd2};
        ev[8] = '{"ld_last_word", instr_alui_a(3'd1, 3'd0, F_ADD, 27'd1023),
                  instr_ld(1'b1, 3'd2, 3'd1, 33'd0), 48'd0, 48'd0, 2,
                  48'd2, 48'd0, 48'd0, 48'd2};
        ev[9] = '{"ld_neg_ea", instr_ld(1'b0, 3'd2, 3'd0, 33'h1_FFFF_FFFF), 48'd0, 48'd0, 48'd0, 1,
                  48'd32, 48'd0, 48'd4, 48'd0};

        av[0] = '{"alu_add", F_ADD, 27'd100, 27'h7FF_FFFF, 48'd99};
        av[1] = '{"alu_sub", F_SUB, 27'd5, 27'd7, 48'hFFFF_FFFF_FFFE};
        av[2] = '{"alu_and", F_AND, 27'h0F0, 27'h0FF, 48'h0F0};
        av[3] = '{"alu_or",  F_OR,  27'h100, 27'h00F, 48'h10F};
        av[4] = '{"alu_xor", F_XOR, 27'h0FF, 27'h00F, 48'h0F0};
        av[5] = '{"alu_shl", F_SHL, 27'd1, 27'd47, 48'h8000_0000_0000};
        av[6] = '{"alu_shr", F_SHR, 27'h7FF_FFF0, 27'd4, 48'h0FFF_FFFF_FFFF};
        av[7] = '{"alu_sar", F_SAR, 27'h7FF_FFF0, 27'd4, 48'hFFFF_FFFF_FFFF};
        av[8] = '{"alu_shl_mask", F_SHL, 27'd3, 27'd65, 48'd6};

        repeat (2) @(negedge clk);
        dut.DMEM.mem[0] = 48'h0000_0ABC_0123;
        dut.DMEM.mem[3] = 48'd0;

        foreach (ev[k]) begin
            prog[0] = ev[k].p0; prog[1] = ev[k].p1; prog[2] = ev[k].p2; prog[3] = ev[k].p3;
            nprog = ev[k].n;
            load_and_reset(ev[k].name);
            run_to_halt(ev[k].name, 100);
            check({ev[k].name, ".pc"}, dut.pc, ev[k].pc);
            check({ev[k].name, ".epc"}, dut.csr_epc, ev[k].epc);
            check({ev[k].name, ".cause"}, dut.csr_cause, ev[k].cause);
            check({ev[k].name, ".instret"}, dut.csr_instret, ev[k].instret);
            check({ev[k].name, ".priv"}, 48'(dut.priv_mode), 48'd3);
            check({ev[k].name, ".status"}, 48'(dut.csr_status[1:0]), 48'd3);
        end
        check("dmem0_untouched", dut.DMEM.mem[0], 48'h0000_0ABC_0123);

        foreach (av[k]) begin
            prog[0] = instr_alui_d(3'd1, 3'd0, F_ADD, av[k].ia);
            prog[1] = instr_alui_d(3'd2, 3'd0, F_ADD, av[k].ib);
            prog[2] = instr_alu(1'b1, 3'd3, 3'd1, 3'd2, av[k].f);
            nprog = 3;
            load_and_reset(av[k].name);
            run_to_halt(av[k].name, 50);
            check({av[k].name, ".d3"}, dut.r_d_regs[3], av[k].exp);
            check({av[k].name, ".instret"}, dut.csr_instret, 48'd3);
        end

        // A bank: writes to A0 are discarded, ALU on A bank, immediate SUB.
        prog[0] = instr_alui_a(3'd0, 3'd0, F_ADD, 27'd5);
        prog[1] = instr_alui_a(3'd1, 3'd0, F_ADD, 27'd7);
        prog[2] = instr_alui_a(3'd2, 3'd1, F_SUB, 27'd2);
        prog[3] = instr_alu(1'b0, 3'd3, 3'd1, 3'd2, F_XOR);
        nprog = 4;
        load_and_reset("abank");
        run_to_halt("abank", 50);
        check("abank.a1", dut.r_a_regs[1], 48'd7);
        check("abank.a2", dut.r_a_regs[2], 48'd5);
        check("abank.a3", dut.r_a_regs[3], 48'd2);
        check("abank.pc", dut.pc, 48'd4);

        // Normal store/load round trip, then HALT freeze.
        prog[0] = instr_alui_d(3'd1, 3'd0, F_ADD, 27'd5);
        prog[1] = instr_st(1'b1, 3'd1, 3'd0, 33'd3);
        prog[2] = instr_ld(1'b1, 3'd2, 3'd0, 33'd3);
        prog[3] = instr_sys(c_SYS_HALT);
        nprog = 4;
        load_and_reset("normal");
        run_to_halt("normal", 50);
        check("normal.dmem3", dut.DMEM.mem[3], 48'd5);
        check("normal.d2", dut.r_d_regs[2], 48'd5);
        check("normal.instret", dut.csr_instret, 48'd3);
        check("normal.halt", 48'(dut.halt), 48'd1);
        check("normal.pc", dut.pc, 48'd3);
        repeat (5) @(negedge clk);
        check("frozen.pc", dut.pc, 48'd3);
        check("frozen.instret", dut.csr_instret, 48'd3);
        check("frozen.d2", dut.r_d_regs[2], 48'd5);

        // Reset asserted mid-program.
        for (int i = 0; i < 4; i++) prog[i] = instr_alui_d(3'd1, 3'd1, F_ADD, 27'd1);
        nprog = 4;
        load_and_reset("midrst");
        repeat (3) @(negedge clk);
        check("midrst.d1_before", dut.r_d_regs[1], 48'd3);
        check("midrst.pc_before", dut.pc, 48'd3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.pc", dut.pc, 48'd0);
        check("midrst.instret", dut.csr_instret, 48'd0);
        check("midrst.d1", dut.r_d_regs[1], 48'd0);
        check("midrst.dmem3_kept", dut.DMEM.mem[3], 48'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
